// File: rtl/dmi_arb_pkg.sv
// dmi_arb_pkg: shared types and constants for the DMI arbiter.
// FSM state enum, latched request bundle, read-latency limit.
package dmi_arb_pkg;

  localparam int AWIDTH = 7;
  localparam int DMI_ARB_MAX_RD_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } dmi_arb_state_e;

  typedef struct packed {
    logic              wr;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       wdata;
  } dmi_req_t;

endpackage

// File: rtl/dmi_arb_if.sv
// dmi_arb_if: requester channels (r0 JTAG DTM, r1 secondary) and DMI port.
// slave = arbiter side, master = requesters + debug module side.
// r0_lock/r1_lock exist only when DMI_ARB_LOCK_EN is defined.
interface dmi_arb_if;
  import dmi_arb_pkg::*;

`ifdef DMI_ARB_LOCK_EN
  logic              r0_lock;
  logic              r1_lock;
`endif
  logic              r0_req_valid;
  logic              r0_req_ready;
  logic              r0_req_wr;
  logic [AWIDTH-1:0] r0_req_addr;
  logic [31:0]       r0_req_wdata;
  logic              r0_rsp_valid;
  logic [31:0]       r0_rsp_rdata;

  logic              r1_req_valid;
  logic              r1_req_ready;
  logic              r1_req_wr;
  logic [AWIDTH-1:0] r1_req_addr;
  logic [31:0]       r1_req_wdata;
  logic              r1_rsp_valid;
  logic [31:0]       r1_rsp_rdata;

  logic              dmi_reg_en;
  logic              dmi_reg_wr_en;
  logic [AWIDTH-1:0] dmi_reg_addr;
  logic [31:0]       dmi_reg_wdata;
  logic [31:0]       dmi_reg_rdata;

  logic              busy;
  logic              owner;

  modport slave (
`ifdef DMI_ARB_LOCK_EN
    input  r0_lock, r1_lock,
`endif
    input  r0_req_valid, r0_req_wr,
    input  r0_req_addr, r0_req_wdata,
    output r0_req_ready,
    output r0_rsp_valid, r0_rsp_rdata,
    input  r1_req_valid, r1_req_wr,
    input  r1_req_addr, r1_req_wdata,
    output r1_req_ready,
    output r1_rsp_valid, r1_rsp_rdata,
    output dmi_reg_en, dmi_reg_wr_en,
    output dmi_reg_addr, dmi_reg_wdata,
    input  dmi_reg_rdata,
    output busy, owner
  );

  modport master (
`ifdef DMI_ARB_LOCK_EN
    output r0_lock, r1_lock,
`endif
    output r0_req_valid, r0_req_wr,
    output r0_req_addr, r0_req_wdata,
    input  r0_req_ready,
    input  r0_rsp_valid, r0_rsp_rdata,
    output r1_req_valid, r1_req_wr,
    output r1_req_addr, r1_req_wdata,
    input  r1_req_ready,
    input  r1_rsp_valid, r1_rsp_rdata,
    input  dmi_reg_en, dmi_reg_wr_en,
    input  dmi_reg_addr, dmi_reg_wdata,
    output dmi_reg_rdata,
    input  busy, owner
  );

endinterface

// File: rtl/dmi_arb_rr.sv
// dmi_arb_rr: 2-way round-robin picker; prio names the preferred side.
// Ports: valid[1:0], prio, (lock_act, lock_idx if DMI_ARB_LOCK_EN) -> gnt, winner.
module dmi_arb_rr (
  input  logic [1:0] valid,
  input  logic       prio,
`ifdef DMI_ARB_LOCK_EN
  input  logic       lock_act,
  input  logic       lock_idx,
`endif
  output logic [1:0] gnt,
  output logic       winner
);

  logic [1:0] elig;

`ifdef DMI_ARB_LOCK_EN
  // A held lock masks out everyone but the lock holder.
  assign elig = lock_act
    ? (valid & (lock_idx ? 2'b10 : 2'b01))
    : valid;
`else
  assign elig = valid;
`endif

  always_comb begin
    winner = 1'b0;
    gnt    = 2'b00;
    unique case (1'b1)
      (elig == 2'b11): begin
        winner = prio;
        gnt    = prio ? 2'b10 : 2'b01;
      end
      (elig == 2'b10): begin
        winner = 1'b1;
        gnt    = 2'b10;
      end
      (elig == 2'b01): begin
        winner = 1'b0;
        gnt    = 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin arbiter/sequencer for the single DMI port.
// Ports: clk, rst_n, bus (dmi_arb_if.slave); param RD_LAT (0..3).
// Optional lock feature: DMI_ARB_LOCK_EN.
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic     clk,
  input logic     rst_n,
  dmi_arb_if.slave bus
);

  localparam int LAT_C =
    (RD_LAT > DMI_ARB_MAX_RD_LAT) ? DMI_ARB_MAX_RD_LAT : RD_LAT;
  localparam int CNT_INIT = (LAT_C > 0) ? LAT_C - 1 : 0;

  dmi_arb_state_e state_q;
  dmi_arb_state_e state_d;
  dmi_req_t       req_q;
  dmi_req_t       req_in;
  logic [1:0]     cnt_q;
  logic [1:0]     cnt_d;
  logic           owner_q;
  logic           prio_q;
  logic [31:0]    rdata0_q;
  logic [31:0]    rdata1_q;
  logic [1:0]     gnt;
  logic           winner;
  logic           idle;
  logic           accept;
  logic           capture;

  assign idle   = (state_q == IDLE);
  assign accept = idle & (|gnt);

`ifdef DMI_ARB_LOCK_EN
  logic locked_q;
  logic owner_lock;
  logic lock_act;

  assign owner_lock = owner_q ? bus.r1_lock : bus.r0_lock;
  assign lock_act   = locked_q & owner_lock;
`endif

  dmi_arb_rr u_rr (
    .valid   ({bus.r1_req_valid, bus.r0_req_valid}),
    .prio    (prio_q),
`ifdef DMI_ARB_LOCK_EN
    .lock_act(lock_act),
    .lock_idx(owner_q),
`endif
    .gnt     (gnt),
    .winner  (winner)
  );

  assign bus.r0_req_ready = idle & gnt[0];
  assign bus.r1_req_ready = idle & gnt[1];

  always_comb begin
    req_in = '0;
    if (winner) begin
      req_in.wr    = bus.r1_req_wr;
      req_in.addr  = bus.r1_req_addr;
      req_in.wdata = bus.r1_req_wdata;
    end else begin
      req_in.wr    = bus.r0_req_wr;
      req_in.addr  = bus.r0_req_addr;
      req_in.wdata = bus.r0_req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (LAT_C == 0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = 2'(CNT_INIT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      req_q    <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q   <= req_in;
        owner_q <= winner;
      end
      if (capture && !owner_q) begin
        rdata0_q <= bus.dmi_reg_rdata;
      end
      if (capture && owner_q) begin
        rdata1_q <= bus.dmi_reg_rdata;
      end
      if (state_q == RESP) begin
        prio_q <= ~owner_q;
      end
    end
  end

`ifdef DMI_ARB_LOCK_EN
  // Lock is taken at completion and dropped once the
  // holder lets go while the arbiter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
    end else if (state_q == RESP) begin
      locked_q <= owner_lock;
    end else if (idle && !owner_lock) begin
      locked_q <= 1'b0;
    end
  end
`endif

  assign bus.dmi_reg_en    = (state_q == ISSUE);
  assign bus.dmi_reg_wr_en = (state_q == ISSUE) & req_q.wr;
  assign bus.dmi_reg_addr  = req_q.addr;
  assign bus.dmi_reg_wdata = req_q.wdata;

  assign bus.r0_rsp_valid = (state_q == RESP) & ~owner_q;
  assign bus.r1_rsp_valid = (state_q == RESP) & owner_q;
  assign bus.r0_rsp_rdata = rdata0_q;
  assign bus.r1_rsp_rdata = rdata1_q;

  assign bus.busy  = ~idle;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: directed bench with a response scoreboard and a
// small DMI register model driving dmi_reg_rdata at RD_LAT.
module tb_dmi_arbiter;
  import dmi_arb_pkg::*;

  parameter int RD_LAT = 1;
  localparam int LI = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dmi_arb_if bus ();

  dmi_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(
    input logic [AWIDTH-1:0] a);
    if (a == 7'h11) return 32'hDEADBEEF;
    return 32'h1000_0000 | 32'(a);
  endfunction

  // DMI register model
  logic [31:0]       dmi_mem [128];
  logic [127:0]      dmi_wrote = '0;
  logic [3:0]        en_hist = '0;
  logic [AWIDTH-1:0] addr_hist [4];
  logic              hit;
  logic [AWIDTH-1:0] raddr;

  always @(posedge clk) begin
    en_hist <= {en_hist[2:0], bus.dmi_reg_en};
    addr_hist[0] <= bus.dmi_reg_addr;
    for (int k = 1; k < 4; k++)
      addr_hist[k] <= addr_hist[k-1];
    if (bus.dmi_reg_en && bus.dmi_reg_wr_en) begin
      dmi_mem[bus.dmi_reg_addr] <= bus.dmi_reg_wdata;
      dmi_wrote[bus.dmi_reg_addr] <= 1'b1;
    end
  end

  assign hit = (RD_LAT == 0) ? bus.dmi_reg_en
                             : en_hist[LI];
  assign raddr = (RD_LAT == 0) ? bus.dmi_reg_addr
                               : addr_hist[LI];
  assign bus.dmi_reg_rdata =
    !hit ? {16'hA5A5, 16'(cyc)}
    : (dmi_wrote[raddr] ? dmi_mem[raddr]
                        : init_val(raddr));

  // bench expectation state
  logic [31:0]  exp_mem [128];
  logic [127:0] exp_wrote = '0;

  function automatic logic [31:0] exp_read(
    input logic [AWIDTH-1:0] a);
    return exp_wrote[a] ? exp_mem[a] : init_val(a);
  endfunction

  typedef struct {
    int                id;
    bit                wr;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    int                acc;
  } sb_t;

  sb_t         sb [$];
  int          grants [$];
  int          en_cyc [$];
  bit          known [2];
  logic [31:0] held [2];
  bit          prev_en = 1'b0;
  bit          lock_phase = 1'b0;
  int          lk_viol = 0;

  task automatic push(input int id);
    sb_t e;
    e.id    = id;
    e.wr    = id ? bus.r1_req_wr : bus.r0_req_wr;
    e.addr  = id ? bus.r1_req_addr : bus.r0_req_addr;
    e.wdata = id ? bus.r1_req_wdata : bus.r0_req_wdata;
    e.acc   = cyc;
    e.rdata = e.wr ? 32'h0 : exp_read(e.addr);
    if (e.wr) begin
      exp_mem[e.addr]   = e.wdata;
      exp_wrote[e.addr] = 1'b1;
    end
    sb.push_back(e);
    grants.push_back(id);
  endtask

  always @(negedge clk) begin : mon
    sb_t  e;
    int   id;
    logic rsp;
    logic rdy;
    if (rst_n) begin
      rsp = bus.r0_rsp_valid | bus.r1_rsp_valid;
      rdy = bus.r0_req_ready | bus.r1_req_ready;
      chk("ready_rsp_excl", rdy & rsp, 1'b0);
      if (rsp) begin
        chk("rsp_one_hot",
            bus.r0_rsp_valid & bus.r1_rsp_valid, 1'b0);
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL rsp_unexpected observed=1 expected=0");
        end
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          id = bus.r1_rsp_valid ? 1 : 0;
          chk("rsp_id", id, e.id);
          chk("rsp_latency", cyc - e.acc, RD_LAT + 2);
          if (!e.wr)
            chk("rsp_rdata",
                id ? bus.r1_rsp_rdata : bus.r0_rsp_rdata,
                e.rdata);
          if (known[1-id])
            chk("other_rdata_held",
                id ? bus.r0_rsp_rdata : bus.r1_rsp_rdata,
                held[1-id]);
          held[id]  = e.rdata;
          known[id] = !e.wr;
        end
      end
      if (bus.dmi_reg_en) begin
        en_cyc.push_back(cyc);
        chk("en_single_cycle", prev_en, 1'b0);
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL en_unexpected observed=1 expected=0");
        end
        if (sb.size() != 0) begin
          chk("dmi_addr", bus.dmi_reg_addr, sb[0].addr);
          chk("dmi_wr_en", bus.dmi_reg_wr_en, sb[0].wr);
          if (sb[0].wr)
            chk("dmi_wdata", bus.dmi_reg_wdata, sb[0].wdata);
        end
      end
      prev_en = bus.dmi_reg_en;
      if (lock_phase && bus.r1_req_ready) lk_viol++;
      if (bus.r0_req_valid && bus.r0_req_ready) push(0);
      if (bus.r1_req_valid && bus.r1_req_ready) push(1);
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic set_req(input int id, input logic v,
                         input logic wr,
                         input logic [AWIDTH-1:0] a,
                         input logic [31:0] d);
    if (id == 0) begin
      bus.r0_req_valid = v;
      bus.r0_req_wr    = wr;
      bus.r0_req_addr  = a;
      bus.r0_req_wdata = d;
    end else begin
      bus.r1_req_valid = v;
      bus.r1_req_wr    = wr;
      bus.r1_req_addr  = a;
      bus.r1_req_wdata = d;
    end
  endtask

  task automatic req(input int id, input logic wr,
                     input logic [AWIDTH-1:0] a,
                     input logic [31:0] d);
    int n = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    set_req(id, 1'b1, wr, a, d);
    while (!got && n < 40) begin
      @(negedge clk);
      got = id ? bus.r1_req_ready : bus.r0_req_ready;
      n++;
    end
    chk($sformatf("accept_r%0d", id), got, 1'b1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < lim, 1'b1);
  endtask

  task automatic wait_grants(input int cnt, input int lim);
    int n = 0;
    while (grants.size() < cnt && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("grant_wait", grants.size() >= cnt, 1'b1);
  endtask

  initial begin
    int n;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
`ifdef DMI_ARB_LOCK_EN
    bus.r0_lock = 1'b0;
    bus.r1_lock = 1'b0;
`endif
    known[0] = 1'b0;
    known[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", bus.dmi_reg_en, 1'b0);
    chk("rst_wr_en", bus.dmi_reg_wr_en, 1'b0);
    chk("rst_addr", bus.dmi_reg_addr, '0);
    chk("rst_wdata", bus.dmi_reg_wdata, '0);
    chk("rst_r0_rsp", bus.r0_rsp_valid, 1'b0);
    chk("rst_r1_rsp", bus.r1_rsp_valid, 1'b0);
    chk("rst_r0_rdata", bus.r0_rsp_rdata, '0);
    chk("rst_r1_rdata", bus.r1_rsp_rdata, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_owner", bus.owner, 1'b0);
    chk("rst_r0_ready", bus.r0_req_ready, 1'b0);
    chk("rst_r1_ready", bus.r1_req_ready, 1'b0);
    rst_n = 1'b1;

    // r0 read of 0x11
    req(0, 1'b0, 7'h11, 32'h0);
    wait_idle(50);
    chk("t1_en_count", en_cyc.size(), 1);
    chk("t1_rdata", bus.r0_rsp_rdata, 32'hDEADBEEF);

    // r1 write of 0x10
    req(1, 1'b1, 7'h10, 32'h0000_0001);
    wait_idle(50);
    chk("t2_en_count", en_cyc.size(), 2);
    chk("t2_r0_kept", bus.r0_rsp_rdata, 32'hDEADBEEF);
    chk("t2_dmi_mem", dmi_mem[16], 32'h1);

    // both continuously valid: alternate
    grants.delete();
    en_cyc.delete();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 7'h11, '0);
    set_req(1, 1'b1, 1'b0, 7'h12, '0);
    n = 0;
    while (grants.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle(50);
    chk("alt_count", grants.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt_grant%0d", i),
          (i < grants.size()) ? grants[i] : -1, i % 2);
    for (int i = 1; i < 6; i++)
      chk($sformatf("alt_en_gap%0d", i),
          (i < en_cyc.size())
            ? en_cyc[i] - en_cyc[i-1] : -1,
          RD_LAT + 3);

    // readback of the r1 write
    req(0, 1'b0, 7'h10, 32'h0);
    wait_idle(50);
    chk("t2b_readback", bus.r0_rsp_rdata, 32'h1);

    // reset in the middle of a transaction
    en_cyc.delete();
    req(0, 1'b0, 7'h20, 32'h0);
    n = 0;
    while (!bus.dmi_reg_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_en_seen", bus.dmi_reg_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_en_drop", bus.dmi_reg_en, 1'b0);
    chk("mid_busy_drop", bus.busy, 1'b0);
    sb.delete();
    grants.delete();
    known[0] = 1'b0;
    known[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_rsp",
          bus.r0_rsp_valid | bus.r1_rsp_valid, 1'b0);
    end
    chk("mid_r0_rdata_clr", bus.r0_rsp_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 7'h11, '0);
    set_req(1, 1'b1, 1'b0, 7'h12, '0);
    wait_grants(1, 40);
    chk("post_rst_first", grants[0], 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    wait_grants(2, 40);
    chk("post_rst_second", grants[1], 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle(50);

`ifdef DMI_ARB_LOCK_EN
    // r0 holds the lock for three accesses
    grants.delete();
    bus.r0_lock = 1'b1;
    req(0, 1'b0, 7'h11, '0);
    lock_phase = 1'b1;
    set_req(1, 1'b1, 1'b0, 7'h12, '0);
    req(0, 1'b0, 7'h13, '0);
    req(0, 1'b1, 7'h14, 32'hCAFE_0001);
    wait_idle(50);
    repeat (3) @(negedge clk);
    lock_phase = 1'b0;
    chk("lock_r1_blocked", lk_viol, 0);
    chk("lock_r0_count", grants.size(), 3);
    @(posedge clk); #1;
    bus.r0_lock = 1'b0;
    wait_grants(4, 40);
    chk("lock_release_grant", grants[3], 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle(50);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the core debug module's single DMI port (dmi_reg_en / dmi_reg_wr_en / dmi_reg_addr / dmi_reg_wdata / dmi_reg_rdata).
- Requester 0 is the JTAG DTM bridge. Requester 1 is a secondary debug master, e.g. the UART/SoC debug bridge.
- Each requester uses a valid/ready request channel and receives a one-cycle response pulse carrying read data.
- Fairness is round-robin. Exactly one DMI transaction is in flight at any time.

Parameters:
- AWIDTH, 7, DMI address width.
- RD_LAT, 1, cycles from the dmi_reg_en cycle to the cycle in which dmi_reg_rdata is valid. Legal range 0..3.

Ports:
- clk  input  1  Block clock. Also the debug module clock.
- rst_n  input  1  Reset. Asynchronous, active-low.
- r0_req_valid / r1_req_valid  input  1  Request valid.
- r0_req_ready / r1_req_ready  output  1  Request accepted this cycle.
- r0_req_wr / r1_req_wr  input  1  1 = write, 0 = read.
- r0_req_addr / r1_req_addr  input  AWIDTH  DMI address.
- r0_req_wdata / r1_req_wdata  input  32  Write data.
- r0_rsp_valid / r1_rsp_valid  output  1  One-cycle completion pulse.
- r0_rsp_rdata / r1_rsp_rdata  output  32  Read data. Held until that requester's next response.
- dmi_reg_en  output  1  DMI access strobe.
- dmi_reg_wr_en  output  1  DMI write strobe.
- dmi_reg_addr  output  AWIDTH  DMI address.
- dmi_reg_wdata  output  32  DMI write data.
- dmi_reg_rdata  input  32  DMI read data.
- busy  output  1  A transaction is in progress (state is not IDLE).
- owner  output  1  Index of the current or last granted requester.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. The state is registered, and every DMI-side output is decoded from registers, so no combinational path runs from requester inputs to DMI outputs.
- Reset (async assert, sync deassert is handled upstream):
  - State = IDLE; prio = 0, so r0 is preferred.
  - dmi_reg_en, dmi_reg_wr_en, both rsp_valid, and busy = 0.
  - dmi_reg_addr, dmi_reg_wdata, both rsp_rdata, and owner = 0.
- IDLE:
  - The winner is the only valid requester; if both are valid, the requester indexed by prio wins.
  - rN_req_ready = (state==IDLE) & winner==N. Ready is combinational from valid and state.
  - On acceptance, latch {wr, addr, wdata} and owner = N, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - dmi_reg_en = 1; dmi_reg_wr_en = latched wr.
  - addr and wdata are driven from the latches and stay stable in every non-IDLE state.
  - If RD_LAT = 0: capture dmi_reg_rdata this cycle and go to RESP. Otherwise load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture dmi_reg_rdata into owner's rsp_rdata and go to RESP.
- RESP (1 cycle):
  - r<owner>_rsp_valid = 1. Writes also pulse rsp_valid; rsp_rdata for a write is the captured value and is don't-care.
  - prio = ~owner. Go to IDLE.
- Latency: acceptance to rsp_valid = RD_LAT+2 cycles. Back-to-back throughput is one transaction per RD_LAT+3 cycles.
- Requesters must hold valid and payload stable until ready. A valid dropped before grant has no effect and causes no error.
- Simultaneous valid from both requesters is always resolved by prio, so neither requester starves.
- The other requester's rsp_rdata is never modified.
- Reset mid-transaction: the transaction is aborted immediately, dmi_reg_en drops asynchronously, and no rsp_valid is issued.
- rsp_valid is never asserted in the same cycle as any req_ready.

Optional Feature:
- Macro: DMI_ARB_LOCK_EN.
- When defined:
  - Inputs r0_lock and r1_lock are added.
  - If the owner's lock is high in RESP, the arbiter enters locked mode. In IDLE only that owner is eligible; the other requester's ready stays low.
  - Lock is released when the owner's lock is sampled low in IDLE. prio then = ~owner.
  - This gives atomic multi-access sequences, e.g. an sbaddress/sbdata pair.
- When not defined: the lock ports are absent and arbitration is pure round-robin.

Decomposition:
- Package dmi_arb_pkg:
  - State enum dmi_arb_state_e.
  - Struct dmi_req_t {wr, addr[AWIDTH], wdata[32]} with AWIDTH as a package constant of 7.
  - Constant DMI_ARB_MAX_RD_LAT = 3.
- Sub-module dmi_arb_rr: a 2-way round-robin picker.
  - Inputs: valid[1:0], prio, plus the lock qualifiers when DMI_ARB_LOCK_EN is defined.
  - Outputs: gnt[1:0] and winner.
  - The FSM, latches and counter stay in the top level.

Test Plan:
- Reset with RD_LAT=1 → all outputs 0 and busy=0. r0 read addr 0x11 with dmi_reg_rdata=0xDEADBEEF in the cycle after en → one dmi_reg_en pulse with wr_en=0 and addr=0x11; r0_rsp_valid 3 cycles after acceptance with rdata 0xDEADBEEF.
- r1 write addr 0x10, wdata 0x00000001 → dmi_reg_en=dmi_reg_wr_en=1 for one cycle with wdata 0x00000001; r1_rsp_valid pulses; r0_rsp_rdata unchanged.
- Both requesters continuously valid for 6 transactions → grants alternate r0,r1,r0,r1,r0,r1; exactly one dmi_reg_en per 4 cycles.
- Reset asserted in WAIT → dmi_reg_en=0 immediately; no rsp_valid; after release, r0 wins the first contention.
- RD_LAT=0 and RD_LAT=3 builds → rsp_valid at acceptance+2 and +5 respectively, and the captured data matches the rdata driven in the correct cycle.
- DMI_ARB_LOCK_EN defined: r0 issues 3 accesses with lock high while r1 is valid → r1_req_ready stays 0 until r0 lock goes low; then r1 is granted next.
